one_four_demux_buf: RTL and testbench



---
 rtl/beef_route_pkg.sv | 15 +
 rtl/one_four_demux_buf_if.sv | 30 +++
 rtl/demux_slot.sv | 45 ++++
 rtl/one_four_demux_buf.sv | 63 ++++++
 tb/tb_one_four_demux_buf.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/beef_route_pkg.sv
// Shared routing definitions for the buffered 1-to-4 demultiplexer:
// channel count, selector type, counter default and a popcount helper.
package beef_route_pkg;

    localparam int NUM_CHAN      = 4;
    localparam int DEFAULT_CNT_W = 16;

    typedef logic [1:0] chan_sel_t;

    // Number of channels handing a word to their consumer in one cycle.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/one_four_demux_buf_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-4 demux.
// slave is the demux view; master is the producer/consumer view.
interface one_four_demux_buf_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = beef_route_pkg::DEFAULT_CNT_W
) ();
    logic                      in_valid;
    logic                      in_ready;
    beef_route_pkg::chan_sel_t in_sel;
    logic [WIDTH-1:0]          in_data;
    logic [3:0]                out_valid;
    logic [3:0]                out_ready;
    logic [WIDTH-1:0]          out_data0;
    logic [WIDTH-1:0]          out_data1;
    logic [WIDTH-1:0]          out_data2;
    logic [WIDTH-1:0]          out_data3;
    logic [CNT_W-1:0]          delivered_cnt;

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               delivered_cnt
    );

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               delivered_cnt
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready; it can take a new word
// whenever it is empty or its current word leaves in the same cycle.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // A load overrides the drain so a refilled slot stays full.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign can_accept = !valid_q || out_ready;

endmodule

// File: rtl/one_four_demux_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted word into one of four
// independent holding slots and counts words handed to the consumers.
module one_four_demux_buf
    import beef_route_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    one_four_demux_buf_if.slave  bus
);
    logic [NUM_CHAN-1:0] slot_load;
    logic [NUM_CHAN-1:0] slot_valid;
    logic [NUM_CHAN-1:0] slot_can_accept;
    logic [WIDTH-1:0]    slot_data [NUM_CHAN];
    logic                in_ready;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Only the addressed slot gates the producer, so a stalled consumer
    // blocks traffic for its own channel only.
    assign in_ready = slot_can_accept[bus.in_sel];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_slot
            assign slot_load[gi] = bus.in_valid && in_ready &&
                                   (bus.in_sel == chan_sel_t'(gi));

            demux_slot #(.WIDTH(WIDTH)) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (slot_load[gi]),
                .load_data  (bus.in_data),
                .out_ready  (bus.out_ready[gi]),
                .valid      (slot_valid[gi]),
                .data       (slot_data[gi]),
                .can_accept (slot_can_accept[gi])
            );
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q + CNT_W'(popcount4(slot_valid & bus.out_ready));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = slot_valid;
    assign bus.out_data0     = slot_data[0];
    assign bus.out_data1     = slot_data[1];
    assign bus.out_data2     = slot_data[2];
    assign bus.out_data3     = slot_data[3];
    assign bus.delivered_cnt = cnt_q;

endmodule

// File: tb/tb_one_four_demux_buf.sv
// Directed bench for one_four_demux_buf with hand-computed expectations.
module tb_one_four_demux_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    one_four_demux_buf_if #(.WIDTH(8), .CNT_W(16)) bus ();

    one_four_demux_buf #(.WIDTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        check_eq({tag, "_d0"}, 32'(bus.out_data0), 32'h0);
        check_eq({tag, "_d1"}, 32'(bus.out_data1), 32'h0);
        check_eq({tag, "_d2"}, 32'(bus.out_data2), 32'h0);
        check_eq({tag, "_d3"}, 32'(bus.out_data3), 32'h0);
        check_eq({tag, "_cnt"}, 32'(bus.delivered_cnt), 32'h0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'b0000;

        // Reset held for two edges with random inputs.
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_sel    = 2'($urandom_range(3));
            bus.in_data   = 8'($urandom);
            bus.out_ready = 4'($urandom);
            step();
        end
        check_all_zero("reset");
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        rst_n = 1'b1;
        step();

        // Single route to channel 2; empty channels with ready are not counted.
        bus.out_ready = 4'b1111;
        bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'hA5;
        #1;
        check_eq("route_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        check_eq("route_valid", 32'(bus.out_valid), 32'h4);
        check_eq("route_d2", 32'(bus.out_data2), 32'hA5);
        check_eq("route_cnt0", 32'(bus.delivered_cnt), 32'h0);
        step();
        check_eq("route_cnt1", 32'(bus.delivered_cnt), 32'h1);
        check_eq("route_drained", 32'(bus.out_valid), 32'h0);

        // Back-pressure on channel 1 only.
        bus.out_ready = 4'b1101;
        send(2'd1, 8'h11);
        check_eq("bp_valid1", 32'(bus.out_valid), 32'h2);
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h22;
        #1;
        check_eq("bp_in_ready_blocked", 32'(bus.in_ready), 32'h0);
        step();
        check_eq("bp_d1_held", 32'(bus.out_data1), 32'h11);
        check_eq("bp_valid_held", 32'(bus.out_valid), 32'h2);
        bus.in_sel = 2'd3; bus.in_data = 8'h33;
        #1;
        check_eq("bp_in_ready_ch3", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        check_eq("bp_valid13", 32'(bus.out_valid), 32'hA);
        check_eq("bp_d3", 32'(bus.out_data3), 32'h33);
        check_eq("bp_d1_still", 32'(bus.out_data1), 32'h11);
        step();
        check_eq("bp_ch3_drained", 32'(bus.out_valid), 32'h2);
        check_eq("bp_cnt2", 32'(bus.delivered_cnt), 32'h2);
        bus.out_ready = 4'b1111;
        step();
        check_eq("bp_ch1_drained", 32'(bus.out_valid), 32'h0);
        check_eq("bp_cnt3", 32'(bus.delivered_cnt), 32'h3);

        // Same-cycle drain and refill on channel 0.
        bus.out_ready = 4'b0000;
        send(2'd0, 8'h77);
        check_eq("refill_full", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 4'b0001;
        bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h5A;
        #1;
        check_eq("refill_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        check_eq("refill_valid", 32'(bus.out_valid), 32'h1);
        check_eq("refill_d0", 32'(bus.out_data0), 32'h5A);
        check_eq("refill_cnt", 32'(bus.delivered_cnt), 32'h4);
        bus.out_ready = 4'b1111;
        step();
        check_eq("refill_cnt5", 32'(bus.delivered_cnt), 32'h5);

        // Stream 65529 words through channel 0 at full rate: count reaches FFFE.
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        for (int i = 0; i < 65529; i++) begin
            bus.in_data = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check_eq("stream_cnt", 32'(bus.delivered_cnt), 32'hFFFE);
        check_eq("stream_empty", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 4'b0000;
        send(2'd0, 8'hC0);
        send(2'd1, 8'hC1);
        send(2'd2, 8'hC2);
        check_eq("wrap_valid", 32'(bus.out_valid), 32'h7);
        check_eq("wrap_pre_cnt", 32'(bus.delivered_cnt), 32'hFFFE);
        bus.out_ready = 4'b0111;
        step();
        check_eq("wrap_cnt", 32'(bus.delivered_cnt), 32'h0001);
        check_eq("wrap_empty", 32'(bus.out_valid), 32'h0);

        // Mid-operation reset with all channels full and an accept in flight.
        bus.out_ready = 4'b0000;
        send(2'd0, 8'hD0);
        send(2'd1, 8'hD1);
        send(2'd2, 8'hD2);
        send(2'd3, 8'hD3);
        check_eq("full_valid", 32'(bus.out_valid), 32'hF);
        check_eq("full_d2", 32'(bus.out_data2), 32'hD2);
        rst_n = 1'b0;
        bus.out_ready = 4'b1111;
        send(2'd1, 8'hEE);
        check_all_zero("midrst");
        rst_n = 1'b1;
        bus.out_ready = 4'b0000;
        send(2'd3, 8'h3C);
        check_eq("post_valid", 32'(bus.out_valid), 32'h8);
        check_eq("post_d3", 32'(bus.out_data3), 32'h3C);
        check_eq("post_cnt0", 32'(bus.delivered_cnt), 32'h0);
        bus.out_ready = 4'b1000;
        step();
        check_eq("post_cnt1", 32'(bus.delivered_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
